// File: rtl/microstep_sequencer_pkg.sv
// Shared definitions for the kwanCPU microstep sequencer.
// Holds the default step width and step count, the step type at the
// default width, and the index of the last fetch-phase step.
package microstep_sequencer_pkg;

  localparam int STEP_W_DEF      = 3;
  localparam int NUM_STEPS_DEF   = 5;
  localparam int FETCH_STEPS_DEF = 2;

  typedef logic [STEP_W_DEF-1:0] step_t;

  // Last step index that still belongs to the fetch phase.
  localparam step_t T_FETCH_LAST = step_t'(FETCH_STEPS_DEF - 1);

endpackage

// File: rtl/microstep_sequencer_if.sv
// Control and status bundle between the control unit and the microstep
// sequencer.
//   run, step_req, step_clr, hlt  : control-word / front-panel requests
//   step, t_onehot, fetch,
//   instr_done, halted            : registered sequencer status
// master = control unit side, slave = sequencer side.
interface microstep_sequencer_if
  import microstep_sequencer_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF
);

  logic                   run;
  logic                   step_req;
  logic                   step_clr;
  logic                   hlt;
  logic [STEP_W-1:0]      step;
  logic [(1<<STEP_W)-1:0] t_onehot;
  logic                   fetch;
  logic                   instr_done;
  logic                   halted;

  modport master (
    output run, step_req, step_clr, hlt,
    input  step, t_onehot, fetch, instr_done, halted
  );

  modport slave (
    input  run, step_req, step_clr, hlt,
    output step, t_onehot, fetch, instr_done, halted
  );

endinterface

// File: rtl/microstep_sequencer_jkff.sv
// JK flip-flop with synchronous active-high reset.
//   clk, reset : clock and synchronous reset (q -> 0)
//   j, k       : 00 hold, 01 clear, 10 set, 11 toggle
//   q          : registered output
module jkff (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/microstep_sequencer.sv
// kwanCPU control-unit microstep (T-state) counter.
// Counts T0..T(NUM_STEPS-1) and wraps, in free-run or manual single-step
// mode, with early end-of-instruction and sticky halt.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of microstep_sequencer_if
//                inputs  run, step_req, step_clr, hlt
//                outputs step, t_onehot, fetch, instr_done, halted
// The step count lives in one jkff per bit; every output is registered.
module microstep_sequencer
  import microstep_sequencer_pkg::*;
#(
  parameter int STEP_W      = STEP_W_DEF,
  parameter int NUM_STEPS   = NUM_STEPS_DEF,
  parameter int FETCH_STEPS = FETCH_STEPS_DEF
) (
  input logic                  clk,
  input logic                  reset,
  microstep_sequencer_if.slave bus
);

  localparam int                ONEHOT_W  = 1 << STEP_W;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [STEP_W-1:0] FETCH_LIM = STEP_W'(FETCH_STEPS);

  if (NUM_STEPS > (1 << STEP_W) || NUM_STEPS < 2 || FETCH_STEPS >= NUM_STEPS)
  begin : g_bad_params
    $error("microstep_sequencer: illegal STEP_W/NUM_STEPS/FETCH_STEPS");
  end

  logic [STEP_W-1:0]   step_q;
  logic [STEP_W-1:0]   next_step;
  logic [ONEHOT_W-1:0] onehot_q;
  logic                fetch_q;
  logic                done_q;
  logic                halted_q;
  logic                step_req_q;
  logic                rise;
  logic                adv;
  logic                wrap;

  always_comb begin
    rise      = bus.step_req & ~step_req_q;
    adv       = ~halted_q & ~bus.hlt & (bus.run | rise);
    wrap      = bus.step_clr | (step_q == LAST_STEP);
    next_step = step_q;
    if (adv) begin
      next_step = wrap ? '0 : step_q + 1'b1;
    end
  end

  // Counter core: bit i toggles when all lower bits are 1 (binary carry);
  // on wrap every bit is driven to clear.
  for (genvar i = 0; i < STEP_W; i++) begin : g_bit
    logic carry;
    logic j;
    logic k;
    if (i == 0) begin : g_c0
      assign carry = 1'b1;
    end else begin : g_cn
      assign carry = &step_q[i-1:0];
    end
    assign j = adv & ~wrap & carry;
    assign k = adv & (wrap | carry);

    jkff bit_ff (
      .clk   (clk),
      .reset (reset),
      .j     (j),
      .k     (k),
      .q     (step_q[i])
    );
  end

  // Decode is taken from the next step so it lands together with the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_req_q <= 1'b0;
      onehot_q   <= ONEHOT_W'(1);
      fetch_q    <= 1'b1;
      done_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      step_req_q <= bus.step_req;
      onehot_q   <= ONEHOT_W'(1) << next_step;
      fetch_q    <= next_step < FETCH_LIM;
      done_q     <= adv & wrap;
      if (bus.hlt) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign bus.step       = step_q;
  assign bus.t_onehot   = onehot_q;
  assign bus.fetch      = fetch_q;
  assign bus.instr_done = done_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_microstep_sequencer.sv
module tb_microstep_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut0: default 3-bit / 5 steps / 2 fetch; dut1: 2-bit / 4 steps / 1 fetch
  microstep_sequencer_if #(.STEP_W(3)) bus0 ();
  microstep_sequencer_if #(.STEP_W(2)) bus1 ();

  microstep_sequencer #(.STEP_W(3), .NUM_STEPS(5), .FETCH_STEPS(2)) dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus0)
  );

  microstep_sequencer #(.STEP_W(2), .NUM_STEPS(4), .FETCH_STEPS(1)) dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus1)
  );

  logic run, req, clr, hlt;
  assign bus0.run = run;  assign bus0.step_req = req;
  assign bus0.step_clr = clr;  assign bus0.hlt = hlt;
  assign bus1.run = run;  assign bus1.step_req = req;
  assign bus1.step_clr = clr;  assign bus1.hlt = hlt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain T-state counter per instance.
  int m_n[2] = '{5, 4};
  int m_f[2] = '{2, 1};
  int m_step[2];
  int m_done[2];
  int m_halt[2];
  int m_prev_req[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_step[k] = 0; m_done[k] = 0; m_halt[k] = 0; m_prev_req[k] = 0;
      end else begin
        bit go;
        go = (m_halt[k] == 0) && !hlt && (run || (req && m_prev_req[k] == 0));
        m_prev_req[k] = req;
        if (hlt) m_halt[k] = 1;
        m_done[k] = 0;
        if (go) begin
          if (clr || m_step[k] == m_n[k] - 1) begin
            m_step[k] = 0;
            m_done[k] = 1;
          end else begin
            m_step[k] = m_step[k] + 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("d0_step",   32'(bus0.step),       32'(m_step[0]));
      check("d0_onehot", 32'(bus0.t_onehot),   32'(1) << m_step[0]);
      check("d0_fetch",  32'(bus0.fetch),      32'(m_step[0] < m_f[0]));
      check("d0_done",   32'(bus0.instr_done), 32'(m_done[0]));
      check("d0_halted", 32'(bus0.halted),     32'(m_halt[0]));
      check("d1_step",   32'(bus1.step),       32'(m_step[1]));
      check("d1_onehot", 32'(bus1.t_onehot),   32'(1) << m_step[1]);
      check("d1_fetch",  32'(bus1.fetch),      32'(m_step[1] < m_f[1]));
      check("d1_done",   32'(bus1.instr_done), 32'(m_done[1]));
      check("d1_halted", 32'(bus1.halted),     32'(m_halt[1]));
    end
  end

  // Apply one cycle of inputs; returns just after the following falling edge.
  task automatic tick(input logic r, input logic rn, input logic rq,
                      input logic cl, input logic h);
    rst = r; run = rn; req = rq; clr = cl; hlt = h;
    @(negedge clk);
    #1;
  endtask

  logic [2:0] seq_step[12] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1,
                              3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
  logic [7:0] seq_oh[5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};

  initial begin
    rst = 1'b1; run = 1'b0; req = 1'b0; clr = 1'b0; hlt = 1'b0;

    // Reset state
    tick(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    check("rst_step",   32'(bus0.step), 32'd0);
    check("rst_onehot", 32'(bus0.t_onehot), 32'h01);
    check("rst_fetch",  32'(bus0.fetch), 32'd1);
    check("rst_done",   32'(bus0.instr_done), 32'd0);
    check("rst_halted", 32'(bus0.halted), 32'd0);

    // 1: free run 12 clocks; dut1 shows the 4-step power-of-two wrap
    for (int i = 0; i < 12; i++) begin
      tick(0, 1, 0, 0, 0);
      check("t1_step", 32'(bus0.step), 32'(seq_step[i]));
      check("t1_onehot", 32'(bus0.t_onehot), 32'(seq_oh[seq_step[i]]));
      check("t1_done", 32'(bus0.instr_done), 32'(i == 4 || i == 9));
      if (i == 2) begin
        check("t6_step3", 32'(bus1.step), 32'd3);
        check("t6_fetch3", 32'(bus1.fetch), 32'd0);
      end
      if (i == 3) begin
        check("t6_wrap", 32'(bus1.step), 32'd0);
        check("t6_done", 32'(bus1.instr_done), 32'd1);
        check("t6_fetch0", 32'(bus1.fetch), 32'd1);
      end
    end

    // 2: early end-of-instruction at step 2
    tick(0, 1, 0, 1, 0);
    check("t2_clr_step", 32'(bus0.step), 32'd0);
    check("t2_clr_done", 32'(bus0.instr_done), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick(0, 1, 0, 0, 0);
      check("t2_resume", 32'(bus0.step), 32'(i));
    end

    // 3: manual single-step with held request
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 0, 0);
    check("t3_held", 32'(bus0.step), 32'd1);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("t3_low", 32'(bus0.step), 32'd1);
    tick(0, 0, 1, 0, 0);
    check("t3_second", 32'(bus0.step), 32'd2);

    // 4: halt at step 3, then try to move it
    tick(0, 1, 0, 0, 0);
    check("t4_at3", 32'(bus0.step), 32'd3);
    tick(0, 1, 0, 0, 1);
    check("t4_hold", 32'(bus0.step), 32'd3);
    check("t4_halted", 32'(bus0.halted), 32'd1);
    for (int i = 0; i < 10; i++) tick(0, 1, logic'(i % 2), 0, 0);
    check("t4_frozen", 32'(bus0.step), 32'd3);
    check("t4_sticky", 32'(bus0.halted), 32'd1);

    // 5: reset out of halt mid-instruction
    tick(1, 1, 0, 0, 0);
    check("t5_step", 32'(bus0.step), 32'd0);
    check("t5_onehot", 32'(bus0.t_onehot), 32'h01);
    check("t5_fetch", 32'(bus0.fetch), 32'd1);
    check("t5_halted", 32'(bus0.halted), 32'd0);
    check("t5_done", 32'(bus0.instr_done), 32'd0);
    tick(0, 1, 0, 0, 0);
    check("t5_res1", 32'(bus0.step), 32'd1);
    tick(0, 1, 0, 0, 0);
    check("t5_res2", 32'(bus0.step), 32'd2);

    // step_clr on the last step: one wrap, one pulse
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    check("clr_last_at4", 32'(bus0.step), 32'd4);
    tick(0, 1, 0, 1, 0);
    check("clr_last_step", 32'(bus0.step), 32'd0);
    check("clr_last_done", 32'(bus0.instr_done), 32'd1);
    tick(0, 1, 0, 0, 0);
    check("clr_last_next", 32'(bus0.step), 32'd1);
    check("clr_last_nodone", 32'(bus0.instr_done), 32'd0);

    // step_clr without an advance is dropped, not remembered
    tick(0, 0, 0, 1, 0);
    check("clr_idle_hold", 32'(bus0.step), 32'd1);
    tick(0, 0, 1, 0, 0);
    check("clr_idle_next", 32'(bus0.step), 32'd2);

    // request rising while running counts once
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0);
    check("rise_run", 32'(bus0.step), 32'd4);

    tick(0, 0, 0, 0, 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
